// File: rtl/oscope_pkg.sv
// Shared types and default constants for the oscilloscope capture engine.
package oscope_pkg;

  localparam int unsigned DEF_SAMPLE_W   = 8;
  localparam int unsigned DEF_FRAME_BITS = 16;
  localparam int unsigned DEF_MSB_POS    = 13;
  localparam int unsigned DEF_DIV_LOG2   = 6;
  localparam int unsigned DEF_DEPTH      = 1024;
  localparam int unsigned DEF_PRE_TRIG   = 256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    POSTTRIG  = 3'd3,
    DONE      = 3'd4
  } cap_state_e;

  // Samples spent in WAIT_TRIG before a trigger is forced.
  function automatic int unsigned auto_trig_timeout(input int unsigned depth,
                                                    input int unsigned pre_trig);
    return depth - pre_trig;
  endfunction

  localparam int unsigned DEF_AUTO_TRIG_TIMEOUT = auto_trig_timeout(DEF_DEPTH, DEF_PRE_TRIG);

endpackage

// File: rtl/oscope_capture_if.sv
// Record readout handshake between the capture engine (slave) and the Pi-side reader (master).
interface oscope_capture_if #(
  parameter int unsigned SAMPLE_W = 8
);
  logic                buf_ready;
  logic                rd_en;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;
  logic                rd_last;

  modport master (
    output rd_en,
    input  buf_ready,
    input  rd_data,
    input  rd_valid,
    input  rd_last
  );

  modport slave (
    input  rd_en,
    output buf_ready,
    output rd_data,
    output rd_valid,
    output rd_last
  );
endinterface

// File: rtl/adc_frame_rx.sv
// Serial ADC frame engine: clock divider, conversion strobe, MSB-first deserialiser
// and sample field extraction with a one-cycle sample strobe.
module adc_frame_rx
  import oscope_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned MSB_POS    = DEF_MSB_POS,
  parameter int unsigned DIV_LOG2   = DEF_DIV_LOG2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_adc_data,
  output logic                o_adc_clk,
  output logic                o_adc_conv,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_stb
);
  localparam int unsigned FCNT_W = $clog2(FRAME_BITS + 3);

  localparam logic [DIV_LOG2:0]   DIV_ALL1   = '1;
  localparam logic [DIV_LOG2:0]   DIV_RISE   = DIV_ALL1 >> 1;
  localparam logic [DIV_LOG2:0]   DIV_ONE    = (DIV_LOG2 + 1)'(1);
  localparam logic [FCNT_W-1:0]   FRAME_LAST = FCNT_W'(FRAME_BITS + 2);
  localparam logic [FCNT_W-1:0]   BIT_LAST   = FCNT_W'(FRAME_BITS - 1);
  localparam logic [FCNT_W-1:0]   CONV_FIRST = FCNT_W'(FRAME_BITS);
  localparam logic [FCNT_W-1:0]   FCNT_ONE   = FCNT_W'(1);

  logic [DIV_LOG2:0]  r_div_cnt;
  logic [FCNT_W-1:0]  r_frame_cnt;
  logic               r_conv;
  logic [MSB_POS:0]   r_shift;
  logic               r_stb;

  logic               w_rise;
  logic               w_wrap;
  logic [FCNT_W-1:0]  w_frame_nxt;

  assign w_rise = (r_div_cnt == DIV_RISE);
  assign w_wrap = (r_div_cnt == DIV_ALL1);

  always_comb begin
    w_frame_nxt = r_frame_cnt;
    if (w_wrap) begin
      w_frame_nxt = (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + FCNT_ONE;
    end
  end

  // Bits above MSB_POS fall off the top of the shifter, so it only spans the field and below.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div_cnt   <= '0;
      r_frame_cnt <= '0;
      r_conv      <= 1'b1;
      r_shift     <= '0;
      r_stb       <= 1'b0;
    end else begin
      r_div_cnt   <= r_div_cnt + DIV_ONE;
      r_frame_cnt <= w_frame_nxt;
      r_conv      <= (w_frame_nxt >= CONV_FIRST);
      if (w_rise && (r_frame_cnt < CONV_FIRST)) begin
        r_shift <= {r_shift[MSB_POS-1:0], i_adc_data};
      end
      r_stb <= w_rise && (r_frame_cnt == BIT_LAST);
    end
  end

  assign o_adc_clk    = r_div_cnt[DIV_LOG2];
  assign o_adc_conv   = r_conv;
  assign o_sample     = r_shift[MSB_POS -: SAMPLE_W];
  assign o_sample_stb = r_stb;

endmodule

// File: rtl/oscope_capture.sv
// Armed, edge-triggered capture engine with circular pre/post-trigger buffer and readout.
// Optional macro OSCOPE_AUTO_TRIG_EN: forces a trigger after a WAIT_TRIG timeout.
module oscope_capture
  import oscope_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned MSB_POS    = DEF_MSB_POS,
  parameter int unsigned DIV_LOG2   = DEF_DIV_LOG2,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned PRE_TRIG   = DEF_PRE_TRIG
) (
  input  logic                osc_clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                trig_rising,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                adc_data,
  output logic                adc_clk,
  output logic                adc_conv,
  oscope_capture_if.slave     rd
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PRE_A     = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);
  localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] A_ONE     = AW'(1);

  cap_state_e          r_state;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_trig_ptr;
  logic [AW-1:0]       r_cnt;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_rising;
  logic [SAMPLE_W-1:0] r_level;
  logic [SAMPLE_W-1:0] r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_last;
  logic [SAMPLE_W-1:0] r_mem [DEPTH];

  logic [SAMPLE_W-1:0] w_smp;
  logic                w_smp_stb;
  logic                w_capturing;
  logic                w_wr_en;
  logic                w_rd_acc;
  logic                w_edge;
  logic                w_force;
  logic                w_trig;

  adc_frame_rx #(
    .SAMPLE_W   (SAMPLE_W),
    .FRAME_BITS (FRAME_BITS),
    .MSB_POS    (MSB_POS),
    .DIV_LOG2   (DIV_LOG2)
  ) u_rx (
    .i_clk        (osc_clk),
    .i_rst_n      (reset_n),
    .i_adc_data   (adc_data),
    .o_adc_clk    (adc_clk),
    .o_adc_conv   (adc_conv),
    .o_sample     (w_smp),
    .o_sample_stb (w_smp_stb)
  );

  assign w_capturing = (r_state == PRETRIG) || (r_state == WAIT_TRIG) || (r_state == POSTTRIG);
  assign w_wr_en     = w_smp_stb && w_capturing;
  assign w_rd_acc    = rd.rd_en && (r_state == DONE);

  // r_prev tracks the last written sample, so the first WAIT_TRIG compare sees the last PRETRIG sample.
  assign w_edge = r_rising ? ((r_prev <  r_level) && (w_smp >= r_level))
                           : ((r_prev >= r_level) && (w_smp <  r_level));

`ifdef OSCOPE_AUTO_TRIG_EN
  localparam logic [AW-1:0] TO_LAST = AW'(auto_trig_timeout(DEPTH, PRE_TRIG) - 1);
  assign w_force = (r_cnt == TO_LAST);
`else
  assign w_force = 1'b0;
`endif

  assign w_trig = w_edge || w_force;

  always_ff @(posedge osc_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_smp;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (w_rd_acc) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_trig_ptr <= '0;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_rising   <= 1'b1;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_rd_last  <= w_rd_acc && (r_cnt == CNT_LAST);
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + A_ONE;
        r_prev   <= w_smp;
      end
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_rising <= trig_rising;
            r_level  <= trig_level;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_state  <= PRETRIG;
          end
        end
        PRETRIG: begin
          if (w_smp_stb) begin
            if (r_cnt == PRE_LAST) begin
              r_cnt   <= '0;
              r_state <= WAIT_TRIG;
            end else begin
              r_cnt <= r_cnt + A_ONE;
            end
          end
        end
        WAIT_TRIG: begin
          if (w_smp_stb) begin
            if (w_trig) begin
              r_trig_ptr <= r_wr_ptr;
              r_cnt      <= '0;
              r_state    <= POSTTRIG;
            end else begin
`ifdef OSCOPE_AUTO_TRIG_EN
              r_cnt <= r_cnt + A_ONE;
`else
              r_cnt <= r_cnt;
`endif
            end
          end
        end
        POSTTRIG: begin
          if (w_smp_stb) begin
            if (r_cnt == POST_LAST) begin
              r_cnt    <= '0;
              r_rd_ptr <= r_trig_ptr - PRE_A;
              r_state  <= DONE;
            end else begin
              r_cnt <= r_cnt + A_ONE;
            end
          end
        end
        DONE: begin
          if (rd.rd_en) begin
            r_rd_ptr <= r_rd_ptr + A_ONE;
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + A_ONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd.buf_ready = (r_state == DONE);
  assign rd.rd_data   = r_rd_data;
  assign rd.rd_valid  = r_rd_valid;
  assign rd.rd_last   = r_rd_last;

endmodule

// File: tb/tb_oscope_capture.sv
// Directed bench for oscope_capture (DIV_LOG2=1, DEPTH=16, PRE_TRIG=4) with a serial ADC model.
module tb_oscope_capture;
  import oscope_pkg::*;

  logic       osc_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       arm = 1'b0;
  logic       trig_rising = 1'b1;
  logic [7:0] trig_level = 8'h00;
  logic       adc_data;
  logic       adc_clk;
  logic       adc_conv;

  int n_tests = 0;
  int n_fail  = 0;

  // ADC model: cur_val is the sample carried by the frame that starts after each conv rise.
  logic [7:0]  cur_val  = 8'h00;
  logic [7:0]  step     = 8'h00;
  logic [7:0]  load_val = 8'h00;
  logic        load_req = 1'b0;
  int unsigned bidx     = 0;
  logic [15:0] adc_word;

  oscope_capture_if #(.SAMPLE_W(8)) rd_if ();

  oscope_capture #(
    .SAMPLE_W   (8),
    .FRAME_BITS (16),
    .MSB_POS    (13),
    .DIV_LOG2   (1),
    .DEPTH      (16),
    .PRE_TRIG   (4)
  ) dut (
    .osc_clk     (osc_clk),
    .reset_n     (reset_n),
    .arm         (arm),
    .trig_rising (trig_rising),
    .trig_level  (trig_level),
    .adc_data    (adc_data),
    .adc_clk     (adc_clk),
    .adc_conv    (adc_conv),
    .rd          (rd_if.slave)
  );

  always #5 osc_clk = ~osc_clk;

  always @(posedge adc_conv) begin
    bidx = 0;
    if (load_req) begin
      cur_val  = load_val;
      load_req = 1'b0;
    end else begin
      cur_val = cur_val + step;
    end
  end

  always @(posedge adc_clk) begin
    if (!adc_conv) bidx = bidx + 1;
  end

  always @* begin
    adc_word = {2'b00, cur_val, 6'b000000};
    adc_data = (bidx < 16) ? adc_word[15 - bidx] : 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge osc_clk);
  endtask

  task automatic wait_conv(input int n);
    logic prev;
    bit   seen;
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      prev = adc_conv;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge osc_clk);
        if (!prev && adc_conv) seen = 1'b1;
        prev = adc_conv;
      end
      if (!seen) begin
        n_fail++;
        $display("FAIL wait_conv: got no adc_conv rise, required one within 200 cycles");
      end
    end
  endtask

  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      @(negedge osc_clk);
      cycles++;
    end while (!dut.w_smp_stb && cycles < 200);
    if (!dut.w_smp_stb) begin
      n_fail++;
      $display("FAIL wait_strobe: got no sample strobe, required one within 200 cycles");
    end
  endtask

  task automatic wait_ready(input int lim);
    int c;
    c = 0;
    while (!rd_if.buf_ready && c < lim) begin
      @(negedge osc_clk);
      c++;
    end
    n_tests++;
    if (rd_if.buf_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: got buf_ready=%b after %0d cycles, required 1", rd_if.buf_ready, lim);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rd_if.rd_en = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (50) tick();
    reset_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (adc_conv !== 1'b1) begin n_fail++; $display("FAIL rst_adc_conv: got %b required 1", adc_conv); end
    n_tests++;
    if (adc_clk !== 1'b0) begin n_fail++; $display("FAIL rst_adc_clk: got %b required 0", adc_clk); end
    n_tests++;
    if (rd_if.buf_ready !== 1'b0) begin n_fail++; $display("FAIL rst_buf_ready: got %b required 0", rd_if.buf_ready); end
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b required 0", rd_if.rd_valid); end
    n_tests++;
    if (rd_if.rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_rd_last: got %b required 0", rd_if.rd_last); end
    n_tests++;
    if (rd_if.rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data: got %h required 00", rd_if.rd_data); end
    reset_n = 1'b1;
    tick();
    rd_if.rd_en = 1'b1;
    tick();
    rd_if.rd_en = 1'b0;
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_valid: got %b required 0", rd_if.rd_valid); end
    wait_conv(2);
    n_tests++;
    if (dut.r_wr_ptr !== 4'd0) begin n_fail++; $display("FAIL idle_no_write: got wr_ptr %0d required 0", dut.r_wr_ptr); end
    n_tests++;
    if (rd_if.buf_ready !== 1'b0) begin n_fail++; $display("FAIL idle_buf_ready: got %b required 0", rd_if.buf_ready); end
  endtask

  task automatic test_frame_decode();
    int cyc;
    step     = 8'h00;
    load_val = 8'hFF;
    load_req = 1'b1;
    wait_conv(1);
    wait_strobe(cyc);
    n_tests++;
    if (dut.w_smp !== 8'hFF) begin n_fail++; $display("FAIL decode_3FC0: got %h required ff", dut.w_smp); end
    wait_strobe(cyc);
    n_tests++;
    if (cyc != 76) begin n_fail++; $display("FAIL strobe_period: got %0d required 76", cyc); end
    load_val = 8'h01;
    load_req = 1'b1;
    wait_conv(1);
    wait_strobe(cyc);
    n_tests++;
    if (dut.w_smp !== 8'h01) begin n_fail++; $display("FAIL decode_0040: got %h required 01", dut.w_smp); end
  endtask

  task automatic test_rising_trigger();
    logic [7:0] e;
    step        = 8'h10;
    load_val    = 8'h00;
    load_req    = 1'b1;
    trig_rising = 1'b1;
    trig_level  = 8'h80;
    wait_conv(1);
    tick();
    pulse_arm();
    // Changing the trigger inputs after arm must not matter.
    trig_rising = 1'b0;
    trig_level  = 8'h00;
    wait_conv(12);
    pulse_arm();
    wait_ready(1500);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_tests++;
        if (rd_if.buf_ready !== 1'b1) begin n_fail++; $display("FAIL rise_ready_before_last: got %b required 1", rd_if.buf_ready); end
      end
      rd_if.rd_en = 1'b1;
      tick();
      e = 8'h40 + 8'(i * 16);
      n_tests++;
      if (rd_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rise_valid[%0d]: got %b required 1", i, rd_if.rd_valid); end
      n_tests++;
      if (rd_if.rd_data !== e) begin n_fail++; $display("FAIL rise_data[%0d]: got %h required %h", i, rd_if.rd_data, e); end
      n_tests++;
      if (rd_if.rd_last !== (i == 15)) begin n_fail++; $display("FAIL rise_last[%0d]: got %b required %b", i, rd_if.rd_last, (i == 15)); end
    end
    n_tests++;
    if (rd_if.buf_ready !== 1'b0) begin n_fail++; $display("FAIL rise_ready_after_last: got %b required 0", rd_if.buf_ready); end
    tick();
    rd_if.rd_en = 1'b0;
    n_tests++;
    if (rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rise_extra_read: got rd_valid %b required 0", rd_if.rd_valid); end
    trig_level = 8'h80;
  endtask

  task automatic test_falling_wrap();
    logic [7:0] e;
    step        = 8'h00;
    load_val    = 8'hC0;
    load_req    = 1'b1;
    trig_rising = 1'b0;
    trig_level  = 8'h80;
    wait_conv(1);
    tick();
    pulse_arm();
    wait_conv(40);
    step = 8'hF0;
    wait_ready(2000);
    step = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rd_if.rd_en = 1'b1;
      tick();
      rd_if.rd_en = 1'b0;
      e = 8'hB0 - 8'(i * 16);
      n_tests++;
      if (rd_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL fall_valid[%0d]: got %b required 1", i, rd_if.rd_valid); end
      n_tests++;
      if (rd_if.rd_data !== e) begin n_fail++; $display("FAIL fall_data[%0d]: got %h required %h", i, rd_if.rd_data, e); end
      n_tests++;
      if (rd_if.rd_last !== (i == 15)) begin n_fail++; $display("FAIL fall_last[%0d]: got %b required %b", i, rd_if.rd_last, (i == 15)); end
      for (int g = 0; g < 2; g++) begin
        tick();
        n_tests++;
        if (rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL fall_gap_valid[%0d.%0d]: got %b required 0", i, g, rd_if.rd_valid); end
      end
    end
    n_tests++;
    if (rd_if.buf_ready !== 1'b0) begin n_fail++; $display("FAIL fall_ready_after: got %b required 0", rd_if.buf_ready); end
  endtask

  task automatic test_auto_trig();
    bit seen_ready;
    step        = 8'h00;
    load_val    = 8'h20;
    load_req    = 1'b1;
    trig_rising = 1'b1;
    trig_level  = 8'h80;
    wait_conv(1);
    tick();
    pulse_arm();
`ifdef OSCOPE_AUTO_TRIG_EN
    wait_ready(3500);
    for (int i = 0; i < 16; i++) begin
      rd_if.rd_en = 1'b1;
      tick();
      n_tests++;
      if (rd_if.rd_data !== 8'h20) begin n_fail++; $display("FAIL auto_data[%0d]: got %h required 20", i, rd_if.rd_data); end
      n_tests++;
      if (rd_if.rd_last !== (i == 15)) begin n_fail++; $display("FAIL auto_last[%0d]: got %b required %b", i, rd_if.rd_last, (i == 15)); end
    end
    rd_if.rd_en = 1'b0;
    tick();
`else
    seen_ready = 1'b0;
    for (int c = 0; c < 3040; c++) begin
      tick();
      if (rd_if.buf_ready) seen_ready = 1'b1;
    end
    n_tests++;
    if (seen_ready) begin n_fail++; $display("FAIL noauto_ready: got buf_ready 1 during wait, required 0"); end
    n_tests++;
    if (dut.r_state !== WAIT_TRIG) begin n_fail++; $display("FAIL noauto_state: got %0d required %0d", dut.r_state, WAIT_TRIG); end
`endif
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    n_tests++;
    if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d required %0d", dut.r_state, IDLE); end
    wait_conv(2);
    n_tests++;
    if (dut.r_wr_ptr !== 4'd0) begin n_fail++; $display("FAIL abort_no_write: got wr_ptr %0d required 0", dut.r_wr_ptr); end
    n_tests++;
    if (rd_if.buf_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b required 0", rd_if.buf_ready); end
  endtask

  initial begin
    rd_if.rd_en = 1'b0;
    test_reset();
    test_frame_decode();
    test_rising_trigger();
    test_falling_wrap();
    test_auto_trig();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
